// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and header-word helpers for the LCD rectangle-fill engine.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_CASET = 8'h2A;
  localparam logic [7:0] LCD_CMD_PASET = 8'h2B;
  localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

  localparam int         PIX_W    = 33;
  localparam logic [3:0] HDR_LAST = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WR_LO = 3'd2,
    ST_WR_HI = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Header word idx as {rs, data}; bytes are zero-extended onto the 16-bit bus.
  function automatic logic [16:0] hdr_word(input logic [3:0]  idx,
                                           input logic [15:0] col_lo,
                                           input logic [15:0] col_hi,
                                           input logic [15:0] row_lo,
                                           input logic [15:0] row_hi);
    case (idx)
      4'd0:    hdr_word = {1'b0, 8'h00, LCD_CMD_CASET};
      4'd1:    hdr_word = {1'b1, 8'h00, col_lo[15:8]};
      4'd2:    hdr_word = {1'b1, 8'h00, col_lo[7:0]};
      4'd3:    hdr_word = {1'b1, 8'h00, col_hi[15:8]};
      4'd4:    hdr_word = {1'b1, 8'h00, col_hi[7:0]};
      4'd5:    hdr_word = {1'b0, 8'h00, LCD_CMD_PASET};
      4'd6:    hdr_word = {1'b1, 8'h00, row_lo[15:8]};
      4'd7:    hdr_word = {1'b1, 8'h00, row_lo[7:0]};
      4'd8:    hdr_word = {1'b1, 8'h00, row_hi[15:8]};
      4'd9:    hdr_word = {1'b1, 8'h00, row_hi[7:0]};
      4'd10:   hdr_word = {1'b0, 8'h00, LCD_CMD_RAMWR};
      default: hdr_word = {1'b0, 16'h0000};
    endcase
  endfunction

  // Widened so a full 65536 x 65536 window gives 2^32 without wrapping.
  function automatic logic [PIX_W-1:0] pix_count(input logic [15:0] col_lo,
                                                 input logic [15:0] col_hi,
                                                 input logic [15:0] row_lo,
                                                 input logic [15:0] row_hi);
    logic [16:0] w_wid;
    logic [16:0] w_hgt;
    w_wid     = {1'b0, col_hi} - {1'b0, col_lo} + 17'd1;
    w_hgt     = {1'b0, row_hi} - {1'b0, row_lo} + 17'd1;
    pix_count = {16'd0, w_wid} * {16'd0, w_hgt};
  endfunction

endpackage

// File: rtl/lcd_wr_strobe.sv
// Times one bus write: wr_n low for WR_LOW cycles then high for WR_HIGH cycles after each go.
module lcd_wr_strobe #(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  output logic wr_n,
  output logic lo_last,
  output logic last_cycle
);

  localparam int CNT_MAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LO_END = CW'(WR_LOW - 1);
  localparam logic [CW-1:0] HI_END = CW'(WR_HIGH - 1);

  logic          r_lo;
  logic          r_hi;
  logic [CW-1:0] r_cnt;
  logic          r_wr_n;

  assign lo_last    = r_lo && (r_cnt == LO_END);
  assign last_cycle = r_hi && (r_cnt == HI_END);
  assign wr_n       = r_wr_n;

  // Phase/counter register; a go on the final high cycle chains straight into the next write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo   <= 1'b0;
      r_hi   <= 1'b0;
      r_cnt  <= '0;
      r_wr_n <= 1'b1;
    end else if (go) begin
      r_lo   <= 1'b1;
      r_hi   <= 1'b0;
      r_cnt  <= '0;
      r_wr_n <= 1'b0;
    end else if (lo_last) begin
      r_lo   <= 1'b0;
      r_hi   <= 1'b1;
      r_cnt  <= '0;
      r_wr_n <= 1'b1;
    end else if (last_cycle) begin
      r_hi   <= 1'b0;
      r_cnt  <= '0;
      r_wr_n <= 1'b1;
    end else if (r_lo || r_hi) begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lcd_fill_sequencer.sv
// Rectangle-fill engine: emits CASET/PASET/RAMWR headers then one colour word per pixel
// on a 16-bit 8080-style LCD bus.
module lcd_fill_sequencer
  import lcd_pkg::*;
#(
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] x0,
  input  logic [15:0] x1,
  input  logic [15:0] y0,
  input  logic [15:0] y1,
  input  logic [15:0] color,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        lcd_cs_n,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic        lcd_rs,
  output logic [15:0] lcd_data_o
);

  state_e             r_state, w_state_nx;
  logic [15:0]        r_x0, r_x1, r_y0, r_y1, r_color;
  logic [3:0]         r_idx, w_idx_nx;
  logic [PIX_W-1:0]   r_pix, w_pix_nx;
  logic               r_cs_n, w_cs_n_nx;
  logic               r_rs, w_rs_nx;
  logic [15:0]        r_data, w_data_nx;
  logic               r_busy, w_busy_nx;
  logic               r_done, w_done_nx;
  logic               r_err, w_err_nx;
  logic               w_go, w_latch, w_lo_last, w_last;
  logic [16:0]        w_hdr;

  lcd_wr_strobe #(
    .WR_LOW  (WR_LOW),
    .WR_HIGH (WR_HIGH)
  ) u_strobe (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (w_go),
    .wr_n       (lcd_wr_n),
    .lo_last    (w_lo_last),
    .last_cycle (w_last)
  );

  assign w_hdr      = hdr_word(r_idx + 4'd1, r_x0, r_x1, r_y0, r_y1);
  assign lcd_cs_n   = r_cs_n;
  assign lcd_rd_n   = 1'b1;
  assign lcd_rs     = r_rs;
  assign lcd_data_o = r_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

  // Next-state and next-output logic; r_idx 0..10 walks the header, 11 means pixel phase.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_pix_nx   = r_pix;
    w_cs_n_nx  = r_cs_n;
    w_rs_nx    = r_rs;
    w_data_nx  = r_data;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_go       = 1'b0;
    w_latch    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy_nx = 1'b0;
        w_cs_n_nx = 1'b1;
        if (start) begin
          w_latch = 1'b1;
          if ((x1 < x0) || (y1 < y0)) begin
            w_err_nx = 1'b1;
          end else begin
            w_state_nx = ST_SETUP;
            w_busy_nx  = 1'b1;
            w_cs_n_nx  = 1'b0;
            w_rs_nx    = 1'b0;
            w_data_nx  = {8'h00, LCD_CMD_CASET};
            w_idx_nx   = 4'd0;
            w_pix_nx   = pix_count(x0, x1, y0, y1);
          end
        end else begin
          w_latch = 1'b0;
        end
      end
      ST_SETUP: begin
        w_go       = 1'b1;
        w_state_nx = ST_WR_LO;
      end
      ST_WR_LO: begin
        if (w_lo_last) begin
          w_state_nx = ST_WR_HI;
        end else begin
          w_state_nx = ST_WR_LO;
        end
      end
      ST_WR_HI: begin
        if (!w_last) begin
          w_state_nx = ST_WR_HI;
        end else if (r_idx < HDR_LAST) begin
          w_idx_nx   = r_idx + 4'd1;
          {w_rs_nx, w_data_nx} = w_hdr;
          w_go       = 1'b1;
          w_state_nx = ST_WR_LO;
        end else if (r_idx == HDR_LAST) begin
          w_idx_nx   = r_idx + 4'd1;
          w_rs_nx    = 1'b1;
          w_data_nx  = r_color;
          w_go       = 1'b1;
          w_state_nx = ST_WR_LO;
        end else if (r_pix != 33'd1) begin
          w_pix_nx   = r_pix - 33'd1;
          w_go       = 1'b1;
          w_state_nx = ST_WR_LO;
        end else begin
          w_state_nx = ST_DONE;
          w_cs_n_nx  = 1'b1;
          w_done_nx  = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
        w_busy_nx  = 1'b0;
        w_rs_nx    = 1'b0;
        w_data_nx  = 16'h0000;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_busy_nx  = 1'b0;
        w_cs_n_nx  = 1'b1;
      end
    endcase
  end

  // State and registered bus/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
      r_pix   <= '0;
      r_cs_n  <= 1'b1;
      r_rs    <= 1'b0;
      r_data  <= 16'h0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_pix   <= w_pix_nx;
      r_cs_n  <= w_cs_n_nx;
      r_rs    <= w_rs_nx;
      r_data  <= w_data_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
    end
  end

  // Window and colour captured on every start sampled in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0    <= 16'h0000;
      r_x1    <= 16'h0000;
      r_y0    <= 16'h0000;
      r_y1    <= 16'h0000;
      r_color <= 16'h0000;
    end else if (w_latch) begin
      r_x0    <= x0;
      r_x1    <= x1;
      r_y0    <= y0;
      r_y1    <= y1;
      r_color <= color;
    end
  end

endmodule
